// File: rtl/seq_detector_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_detector_pkg;

  // Default maximum pattern length and the matching cfg_len field width.
  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_LEN_W = $clog2(DEF_PAT_W + 1);

  // Configuration loaded whenever the block comes out of reset.
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 8'b0000_1101;
  localparam int unsigned          DEF_LENGTH  = 4;
  localparam bit                   DEF_OVERLAP = 1'b1;

  // A length of zero or one beyond the history depth means "use the full depth".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_detector_hist.sv
// Shift history and fill counter for the serial pattern detector.
// Exposes the candidate history and fill value that the next valid bit would
// produce, so the compare logic can decide on a hit in the same cycle.
module seq_detector_hist #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned FW    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             in_bit,
  input  logic             discard,
  output logic [PAT_W-1:0] cand,
  output logic [FW-1:0]    nfill
);

  logic [PAT_W-1:0] hist_q;
  logic [FW-1:0]    fill_q;

  // The oldest history bit falls off the end on every shift and is never compared.
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

  assign cand  = {hist_q[PAT_W-2:0], in_bit};
  assign nfill = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;

  // Shift in each accepted bit; a non-overlapping hit throws the history away.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= cand;
      fill_q <= discard ? '0 : nfill;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with a registered match pulse.
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int unsigned          PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]     DEF_PAT = DEF_PATTERN,
  parameter int unsigned          DEF_LEN = DEF_LENGTH,
  parameter bit                   DEF_OVL = DEF_OVERLAP,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  output logic                         match_o,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int unsigned LEN_W = (PAT_W == DEF_PAT_W) ? DEF_LEN_W : $clog2(PAT_W + 1);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] nfill;
  logic             shift;
  logic             hit;
  logic             discard;

  // A configuration load takes the cycle, so the bit offered alongside it is dropped.
  assign shift = in_valid && !cfg_load;

  seq_detector_hist #(
    .PAT_W (PAT_W),
    .FW    (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_load),
    .shift   (shift),
    .in_bit  (in_bit),
    .discard (discard),
    .cand    (cand),
    .nfill   (nfill)
  );

  // Select only the low len bits of history and pattern for comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hit     = shift && (nfill >= len_q) && (((cand ^ pat_q) & mask) == '0);
  assign discard = hit && !ovl_q;

  // Configuration registers: defaults on reset, clamped length on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= DEF_PAT;
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= DEF_OVL;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= LEN_W'(clamp_len(32'(cfg_len), PAT_W));
      ovl_q <= cfg_overlap;
    end
  end

  // Registered one-cycle match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_o <= 1'b0;
    end else begin
      match_o <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating hit counter; an explicit clear beats a simultaneous hit.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios followed by a
// randomized stream, all compared against a bit-queue reference model.
// Counter expectations follow SEQDET_MATCH_CNT_EN when it is defined.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LW    = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             match_o;
  logic             cnt_clr;
  logic [CNT_W-1:0] match_cnt;

  // Reference model state: the bits received since the last clear, oldest first.
  bit               rx_q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               exp_match;
  int               exp_cnt;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W   (PAT_W),
    .DEF_PAT (8'b0000_1101),
    .DEF_LEN (4),
    .DEF_OVL (1'b1),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match_o     (match_o),
    .cnt_clr     (cnt_clr),
    .match_cnt   (match_cnt)
  );

  task automatic modelReset();
    rx_q.delete();
    m_pat     = 8'b0000_1101;
    m_len     = 4;
    m_ovl     = 1'b1;
    exp_match = 1'b0;
    exp_cnt   = 0;
  endtask

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic modelStep();
    bit hit;
    hit = 1'b0;
    if (rst) begin
      modelReset();
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = ((cfg_len == 0) || (int'(cfg_len) > PAT_W)) ? PAT_W : int'(cfg_len);
        m_ovl = cfg_overlap;
        rx_q.delete();
        exp_match = 1'b0;
      end else if (in_valid) begin
        rx_q.push_back(in_bit);
        if (rx_q.size() > PAT_W) void'(rx_q.pop_front());
        if (rx_q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++) begin
            if (rx_q[rx_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
          end
        end
        exp_match = hit;
        if (hit && !m_ovl) rx_q.delete();
      end else begin
        exp_match = 1'b0;
      end
`ifdef SEQDET_MATCH_CNT_EN
      if (cnt_clr) exp_cnt = 0;
      else if (hit && (exp_cnt < (1 << CNT_W) - 1)) exp_cnt++;
`else
      exp_cnt = 0;
`endif
    end
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (match_o === exp_match)
    else begin
      bad++;
      $error("[TB] FAIL %s match_o observed=%0b expected=%0b", tag, match_o, exp_match);
    end
    total++;
    assert (match_cnt === CNT_W'(exp_cnt))
    else begin
      bad++;
      $error("[TB] FAIL %s match_cnt observed=%0d expected=%0d", tag, match_cnt, exp_cnt);
    end
    if (match_o === 1'b1) pulses++;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit b, input bit ld,
                               input logic [PAT_W-1:0] p, input int l, input bit o,
                               input bit clr, input string tag);
    rst         = r;
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = p;
    cfg_len     = LW'(l);
    cfg_overlap = o;
    cnt_clr     = clr;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic sendBit(input bit b, input string tag);
    applyStimulus(1'b0, 1'b1, b, 1'b0, '0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic loadCfg(input logic [PAT_W-1:0] p, input int l, input bit o, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0, tag);
  endtask

  // Bits go out MSB first: bits[n-1] is the first bit on the wire.
  task automatic sendStream(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i], tag);
  endtask

  task automatic checkPulses(input string tag, input int want);
    total++;
    assert (pulses === want)
    else begin
      bad++;
      $error("[TB] FAIL %s pulse count observed=%0d expected=%0d", tag, pulses, want);
    end
    pulses = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    modelReset();

    $display("[TB] reset defaults");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, "reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, "reset_valid");
    pulses = 0;

    $display("[TB] overlapping default 1101");
    sendStream(32'b1101101, 7, "ovl_stream");
    checkPulses("ovl_pulses", 2);

    $display("[TB] non-overlapping 1101");
    loadCfg(8'b0000_1101, 4, 1'b0, "load_novl");
    sendStream(32'b1101101, 7, "novl_stream");
    checkPulses("novl_pulses", 1);

    $display("[TB] valid gaps");
    loadCfg(8'b0000_1101, 4, 1'b1, "load_gap");
    sendBit(1'b1, "gap_b1");
    sendBit(1'b1, "gap_b2");
    idle("gap_idle1");
    idle("gap_idle2");
    idle("gap_idle3");
    sendBit(1'b0, "gap_b3");
    sendBit(1'b1, "gap_b4");
    idle("gap_after");
    checkPulses("gap_pulses", 1);

    $display("[TB] load with coincident valid");
    loadCfg(8'b0000_1101, 4, 1'b1, "load_pre8");
    sendStream(32'b10101, 5, "fill5");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'b1010_1010, 8, 1'b1, 1'b0, "load_valid");
    sendStream(32'b10101010, 8, "len8_stream");
    checkPulses("len8_pulses", 1);

    $display("[TB] clamped length");
    loadCfg(8'b1010_1010, 0, 1'b1, "load_len0");
    sendStream(32'b1010101010, 10, "len0_stream");
    checkPulses("len0_pulses", 2);
    loadCfg(8'b1010_1010, 12, 1'b1, "load_len12");
    sendStream(32'b10101010, 8, "len12_stream");
    checkPulses("len12_pulses", 1);

    $display("[TB] length one");
    loadCfg(8'b0000_0001, 1, 1'b1, "load_len1");
    sendStream(32'b1101, 4, "len1_stream");
    checkPulses("len1_pulses", 3);

    $display("[TB] counter clear against hit");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1, "clr_hit");
    sendBit(1'b1, "post_clr_hit");
    checkPulses("clr_pulses", 2);

    $display("[TB] reset mid-stream");
    loadCfg(8'b0000_1101, 4, 1'b0, "load_prerst");
    sendStream(32'b110, 3, "prerst_stream");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, "mid_reset");
    sendStream(32'b1101, 4, "postrst_stream");
    checkPulses("rst_pulses", 1);

    $display("[TB] randomized stream");
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      int          l;
      r = $urandom_range(0, 99);
      l = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 15));
      if (r == 99)
        applyStimulus(1'b1, 1'b1, 1'($urandom), 1'b0, '0, 0, 1'b0, 1'b0, "rand_rst");
      else if (r < 4)
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b1, PAT_W'($urandom), l,
                      1'($urandom), 1'b0, "rand_load");
      else
        applyStimulus(1'b0, (r < 80), 1'($urandom), 1'b0, '0, 0, 1'b0, (r >= 4 && r < 7),
                      "rand_step");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector, the generalised successor of the fixed 4-bit Mealy detectors in the sequential-circuits set.
- Pattern, length and overlap mode are runtime-programmable up to PAT_W bits.
- Input is qualified by a valid strobe. Output is a registered one-cycle match pulse, plus an optional saturating match counter.
- Sits after a serial receiver or bit-slicer; drives interrupt or flag logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- DEF_PAT, 8'b0000_1101, pattern loaded at reset (PAT_W bits, LSB-aligned).
- DEF_LEN, 4, pattern length loaded at reset (1..PAT_W).
- DEF_OVL, 1, overlap mode loaded at reset (1 = overlapping, 0 = non-overlapping).
- CNT_W, 16, match counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_bit this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  load configuration this cycle.
- cfg_pattern  in  PAT_W  pattern; bit len-1 is the first bit received, bit 0 the last.
- cfg_len  in  $clog2(PAT_W+1)  pattern length.
- cfg_overlap  in  1  overlap mode.
- match_o  out  1  one-cycle pulse on detection.
- cnt_clr  in  1  clear match counter (optional feature only).
- match_cnt  out  CNT_W  saturating match count (optional feature only).

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - match_o=0, history=0, fill=0, match_cnt=0.
  - pattern=DEF_PAT, len=DEF_LEN, overlap=DEF_OVL.
- Internal state:
  - hist[PAT_W-1:0] is a shift history, newest bit in bit 0.
  - fill counts valid history bits and saturates at PAT_W.
- cfg_load=1:
  - Latches pattern, len and overlap.
  - Clears hist and fill; match_o=0 next cycle.
  - Has priority over in_valid in the same cycle; that in_bit is discarded.
  - cfg_len of 0 or greater than PAT_W is clamped to PAT_W.
- in_valid=1 (no cfg_load):
  - cand = {hist[PAT_W-2:0], in_bit}; nfill = min(fill+1, PAT_W).
  - hit = (nfill >= len) && (cand[len-1:0] == pattern[len-1:0]).
  - hist <= cand; match_o <= hit.
  - If hit && !overlap: fill <= 0 (history discarded, no bit reuse). Otherwise fill <= nfill.
- in_valid=0: hist and fill hold; match_o <= 0.
- Latency: match_o rises in the cycle after the clock edge that samples the final pattern bit. Back-to-back hits give consecutive high cycles.
- len=1: every valid bit equal to pattern[0] produces a hit.
- There is no explicit FSM; the history/fill scheme replaces the fixed state chain. Behaviour equals a KMP automaton with full-fallback overlap.
- Reset asserted mid-stream: any partial match is lost and configuration returns to defaults.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments on each hit and saturates at 2^CNT_W-1.
  - cnt_clr=1 zeroes it next cycle and wins over a simultaneous hit (result 0).
  - cfg_load does not clear the counter.
- Undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are synthesised.

Decomposition:
- Package seq_detector_pkg holds:
  - localparam for the cfg_len width.
  - Default pattern/len/overlap constants.
  - function clamp_len().
- One sub-module, seq_detector_hist: shift history plus fill counter with clear and no-reuse control. Compare and counter logic stay in the top.

Test Plan:
- Reset defaults (1101, len 4, overlap), in_valid=1, stream 1,1,0,1,1,0,1 -> match_o high on the cycles after bits 4 and 7; otherwise 0.
- cfg_load pattern 1101, len 4, overlap=0, same stream -> single pulse after bit 4; no pulse after bit 7.
- Valid gaps: stream 1,1,0,1 with in_valid=0 for 3 cycles between bits 2 and 3 -> exactly one pulse, one cycle after bit 4 is sampled; match_o=0 during the gaps.
- cfg_load pattern 8'b1010_1010, len 8 while fill=5, with in_valid=1 in the same cycle -> bit discarded, history cleared; the next 8 bits 10101010 give a pulse only after the 8th bit.
- Clamp and edge lengths: cfg_len=0 -> behaves as len 8. len 1, pattern[0]=1, stream 1,1,0,1 -> pulses after bits 1, 2 and 4.
- With SEQDET_MATCH_CNT_EN, CNT_W=2:
  - 5 hits -> match_cnt=3 (saturated).
  - cnt_clr coincident with a hit -> match_cnt=0.
  - rst mid-stream -> match_cnt=0, match_o=0, defaults restored.
